// File: rtl/vend_credit_fsm.sv
// ---------------------------------------------------------------------------
// vend_credit_fsm
//   Single-clock coin-accumulating vending controller. It collects 50/100/200
//   coin pushes until the credit reaches PRICE. It then holds a vend strobe
//   for VEND_CYCLES cycles. After that it pays out any change, or the whole
//   credit on cancel, as single-coin pulses separated by CHANGE_GAP idle
//   cycles.
//
//   Optional build macro: VEND_TIMEOUT_EN
//     When defined, an inactivity timer in COLLECT forces a refund after
//     TIMEOUT_CYCLES cycles without an accepted coin.
//
// Ports
//   CLOCK_50    in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   coin50/100/200  in  debounced levels, rising edge inserts the coin
//   cancel      in   debounced level, rising edge requests a refund
//   credit      out  accumulated credit, or remaining payout in CHANGE/REFUND
//   vend        out  dispense strobe (registered)
//   chg50/100/200   out  one-cycle coin eject pulses (registered)
//   coin_reject out  one-cycle pulse, a detected coin edge was not accepted
//   busy        out  high in VEND, CHANGE and REFUND
//   state       out  IDLE=0 COLLECT=1 VEND=2 CHANGE=3 REFUND=4
// ---------------------------------------------------------------------------
module vend_credit_fsm #(
  parameter int PRICE          = 250,
  parameter int CREDIT_W       = 10,
  parameter int VEND_CYCLES    = 4,
  parameter int CHANGE_GAP     = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                coin50,
  input  logic                coin100,
  input  logic                coin200,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend,
  output logic                chg50,
  output logic                chg100,
  output logic                chg200,
  output logic                coin_reject,
  output logic                busy,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VEND    = 3'd2,
    S_CHANGE  = 3'd3,
    S_REFUND  = 3'd4
  } state_t;

  // A gap of zero would put two eject pulses back to back, so at least one
  // idle cycle is always inserted.
  localparam int GAP_EFF = (CHANGE_GAP < 1) ? 1 : CHANGE_GAP;
  localparam int VCW     = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
  localparam int GW      = $clog2(GAP_EFF + 1);

  localparam logic [CREDIT_W:0]   MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [CREDIT_W:0]   PRICE_X    = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] C50        = CREDIT_W'(50);
  localparam logic [CREDIT_W-1:0] C100       = CREDIT_W'(100);
  localparam logic [CREDIT_W-1:0] C200       = CREDIT_W'(200);

  // Input bit order: 0=coin50 1=coin100 2=coin200 3=cancel
  logic [3:0] raw;
  logic [3:0] s1_reg, s2_reg, edge_reg, edge_det;

  state_t              state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic [VCW-1:0]      vend_cnt_reg, vend_cnt_next;
  logic [GW-1:0]       gap_reg, gap_next;
  logic                vend_reg, vend_next;
  logic [2:0]          chg_reg, chg_next;        // {chg200, chg100, chg50}
  logic                reject_reg, reject_next;

`ifdef VEND_TIMEOUT_EN
  localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMW-1:0] timer_reg, timer_next;
`endif

  assign raw = {cancel, coin200, coin100, coin50};

  for (genvar gi = 0; gi < 4; gi++) begin : g_edge
    assign edge_det[gi] = s1_reg[gi] & ~s2_reg[gi];
  end

  // History registers reset to 1 so a key held through reset is not counted.
  // The detected edge is registered once more before the FSM consumes it.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1_reg   <= 4'hF;
      s2_reg   <= 4'hF;
      edge_reg <= 4'h0;
    end else begin
      s1_reg   <= raw;
      s2_reg   <= s1_reg;
      edge_reg <= edge_det;
    end
  end

  // Coin arbitration: 50 > 100 > 200; losers of a simultaneous push are rejected.
  logic                coin_any, coin_extra;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W-1:0] change_amt;

  assign coin_any   = |edge_reg[2:0];
  assign coin_extra = (edge_reg[0] & (edge_reg[1] | edge_reg[2])) | (edge_reg[1] & edge_reg[2]);
  assign coin_val   = edge_reg[0] ? C50 : (edge_reg[1] ? C100 : C200);
  assign coin_sum   = {1'b0, credit_reg} + {1'b0, coin_val};
  assign change_amt = coin_sum[CREDIT_W-1:0] - PRICE_X[CREDIT_W-1:0];

  // Greedy payout choice always works on the current remaining amount.
  logic [2:0]          pay_sel;
  logic [CREDIT_W-1:0] pay_val;

  always_comb begin
    pay_sel = 3'b001;
    pay_val = C50;
    if (credit_reg >= C200) begin
      pay_sel = 3'b100;
      pay_val = C200;
    end else if (credit_reg >= C100) begin
      pay_sel = 3'b010;
      pay_val = C100;
    end
  end

  always_comb begin
    state_next    = state_reg;
    credit_next   = credit_reg;
    vend_cnt_next = vend_cnt_reg;
    gap_next      = gap_reg;
    vend_next     = 1'b0;
    chg_next      = 3'b000;
    reject_next   = 1'b0;
`ifdef VEND_TIMEOUT_EN
    timer_next    = timer_reg;
`endif

    unique case (state_reg)
      S_IDLE, S_COLLECT: begin
        if (coin_any) begin
          // A coin wins over a cancel edge in the same cycle.
          if (coin_extra) reject_next = 1'b1;
          if (coin_sum > MAX_CREDIT) begin
            reject_next = 1'b1;
          end else if (coin_sum >= PRICE_X) begin
            state_next    = S_VEND;
            credit_next   = change_amt;
            vend_next     = 1'b1;
            vend_cnt_next = VCW'(VEND_CYCLES - 1);
          end else begin
            state_next  = S_COLLECT;
            credit_next = coin_sum[CREDIT_W-1:0];
`ifdef VEND_TIMEOUT_EN
            timer_next  = '0;
`endif
          end
        end else if (state_reg == S_COLLECT && edge_reg[3]) begin
          state_next  = S_REFUND;
          chg_next    = pay_sel;
          credit_next = credit_reg - pay_val;
          gap_next    = GW'(GAP_EFF);
        end
`ifdef VEND_TIMEOUT_EN
        else if (state_reg == S_COLLECT) begin
          if (timer_reg == TMW'(TIMEOUT_CYCLES - 1)) begin
            state_next  = S_REFUND;
            chg_next    = pay_sel;
            credit_next = credit_reg - pay_val;
            gap_next    = GW'(GAP_EFF);
          end else begin
            timer_next = timer_reg + TMW'(1);
          end
        end
`endif
      end

      S_VEND: begin
        if (coin_any) reject_next = 1'b1;
        if (vend_cnt_reg == '0) begin
          if (credit_reg != '0) begin
            // First change pulse lands in the first CHANGE cycle.
            state_next  = S_CHANGE;
            chg_next    = pay_sel;
            credit_next = credit_reg - pay_val;
            gap_next    = GW'(GAP_EFF);
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          vend_next     = 1'b1;
          vend_cnt_next = vend_cnt_reg - VCW'(1);
        end
      end

      S_CHANGE, S_REFUND: begin
        if (coin_any) reject_next = 1'b1;
        if (credit_reg == '0) begin
          // credit was decremented with the last pulse, so this is its cycle.
          state_next = S_IDLE;
        end else if (gap_reg == '0) begin
          chg_next    = pay_sel;
          credit_next = credit_reg - pay_val;
          gap_next    = GW'(GAP_EFF);
        end else begin
          gap_next = gap_reg - GW'(1);
        end
      end

      default: begin
        state_next  = S_IDLE;
        credit_next = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      credit_reg   <= '0;
      vend_cnt_reg <= '0;
      gap_reg      <= '0;
      vend_reg     <= 1'b0;
      chg_reg      <= 3'b000;
      reject_reg   <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      timer_reg    <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      credit_reg   <= credit_next;
      vend_cnt_reg <= vend_cnt_next;
      gap_reg      <= gap_next;
      vend_reg     <= vend_next;
      chg_reg      <= chg_next;
      reject_reg   <= reject_next;
`ifdef VEND_TIMEOUT_EN
      timer_reg    <= timer_next;
`endif
    end
  end

  assign credit      = credit_reg;
  assign vend        = vend_reg;
  assign chg50       = chg_reg[0];
  assign chg100      = chg_reg[1];
  assign chg200      = chg_reg[2];
  assign coin_reject = reject_reg;
  assign busy        = (state_reg == S_VEND) || (state_reg == S_CHANGE) || (state_reg == S_REFUND);
  assign state       = state_reg;

endmodule

// File: tb/tb_vend_credit_fsm.sv
// ---------------------------------------------------------------------------
// tb_vend_credit_fsm
//   Scoreboard bench for vend_credit_fsm (PRICE=250, VEND_CYCLES=4,
//   CHANGE_GAP=2, TIMEOUT_CYCLES=10). Output pulses (vend, chg*, coin_reject)
//   are collected by a monitor as {kind, start cycle, length}. Each one is
//   compared against the expectation pushed when the stimulus was driven.
//   Scenario tasks also check credit/state inline.
// ---------------------------------------------------------------------------
module tb_vend_credit_fsm;

  logic       clk;
  logic       reset;
  logic       coin50, coin100, coin200, cancel;
  logic [9:0] credit;
  logic       vend, chg50, chg100, chg200, coin_reject, busy;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int code;   // 0 vend, 1 chg50, 2 chg100, 3 chg200, 4 coin_reject
    int start;
    int len;
  } ev_t;

  ev_t   exp_q[$];
  string ev_name[5] = '{"vend", "chg50", "chg100", "chg200", "coin_reject"};

  vend_credit_fsm #(
    .PRICE(250), .CREDIT_W(10), .VEND_CYCLES(4), .CHANGE_GAP(2), .TIMEOUT_CYCLES(10)
  ) dut (
    .CLOCK_50(clk), .reset(reset),
    .coin50(coin50), .coin100(coin100), .coin200(coin200), .cancel(cancel),
    .credit(credit), .vend(vend), .chg50(chg50), .chg100(chg100), .chg200(chg200),
    .coin_reject(coin_reject), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int code, input int start, input int len);
    ev_t e;
    e.code  = code;
    e.start = start;
    e.len   = len;
    exp_q.push_back(e);
  endtask

  // Records each completed output pulse and pops the matching expectation.
  task automatic monitor();
    logic [4:0] prev;
    logic [4:0] cur;
    int         start_c[5];
    ev_t        e;
    prev = '0;
    for (int k = 0; k < 5; k++) start_c[k] = 0;
    forever begin
      @(negedge clk);
      cur = {coin_reject === 1'b1, chg200 === 1'b1, chg100 === 1'b1, chg50 === 1'b1, vend === 1'b1};
      if (cur[3:1] != 3'b000) begin
        checks++;
        if ($countones(cur[3:1]) != 1) begin
          failures++;
          $display("FAIL chg_onehot: cyc=%0d chg200/100/50=%b required one-hot", cyc, cur[3:1]);
        end
      end
      for (int k = 0; k < 5; k++) begin
        if (cur[k] && !prev[k]) start_c[k] = cyc;
        if (!cur[k] && prev[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s: pulse start=%0d len=%0d, none expected",
                     ev_name[k], start_c[k], cyc - start_c[k]);
          end else begin
            e = exp_q.pop_front();
            if (e.code !== k || e.start !== start_c[k] || e.len !== (cyc - start_c[k])) begin
              failures++;
              $display("FAIL event: got %s start=%0d len=%0d, required %s start=%0d len=%0d",
                       ev_name[k], start_c[k], cyc - start_c[k], ev_name[e.code], e.start, e.len);
            end
          end
        end
      end
      prev = cur;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // mask bits: 0 coin50, 1 coin100, 2 coin200, 3 cancel. t0 = cycle of drive.
  // Returns two cycles later with the inputs released.
  task automatic coin_pulse(input logic [3:0] mask, output int t0);
    @(negedge clk);
    {cancel, coin200, coin100, coin50} = mask;
    t0 = cyc;
    repeat (2) @(negedge clk);
    {cancel, coin200, coin100, coin50} = 4'b0000;
  endtask

  task automatic drain_check(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_events: %0d outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    coin100 = 1'b1;   // held through reset, must not count
    repeat (3) @(negedge clk);
    checks++; if (state !== 3'd0)   begin failures++; $display("FAIL reset_state: got %0d required 0", state); end
    checks++; if (credit !== 10'd0) begin failures++; $display("FAIL reset_credit: got %0d required 0", credit); end
    checks++; if (vend !== 1'b0)    begin failures++; $display("FAIL reset_vend: got %b required 0", vend); end
    checks++; if ({chg200, chg100, chg50} !== 3'b000) begin failures++; $display("FAIL reset_chg: got %b required 000", {chg200, chg100, chg50}); end
    checks++; if (coin_reject !== 1'b0) begin failures++; $display("FAIL reset_reject: got %b required 0", coin_reject); end
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (credit !== 10'd0) begin failures++; $display("FAIL held_key_credit: got %0d required 0", credit); end
    checks++; if (state !== 3'd0)   begin failures++; $display("FAIL held_key_state: got %0d required 0", state); end
    coin100 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_exact_price();
    int t0;
    coin_pulse(4'b0001, t0);
    checks++; if (credit !== 10'd0)  begin failures++; $display("FAIL latency_early: credit=%0d at t0+2, required 0", credit); end
    wait_until(t0 + 3);
    checks++; if (credit !== 10'd50) begin failures++; $display("FAIL credit_50: got %0d required 50", credit); end
    checks++; if (state !== 3'd1)    begin failures++; $display("FAIL collect_state: got %0d required 1", state); end
    coin_pulse(4'b0010, t0);
    wait_until(t0 + 3);
    checks++; if (credit !== 10'd150) begin failures++; $display("FAIL credit_150: got %0d required 150", credit); end
    coin_pulse(4'b0010, t0);
    push_exp(0, t0 + 3, 4);
    wait_until(t0 + 3);
    checks++; if (state !== 3'd2 || busy !== 1'b1) begin failures++; $display("FAIL vend_state: got state=%0d busy=%b required 2/1", state, busy); end
    checks++; if (credit !== 10'd0) begin failures++; $display("FAIL vend_nochange_credit: got %0d required 0", credit); end
    wait_until(t0 + 8);
    checks++; if (state !== 3'd0 || credit !== 10'd0) begin failures++; $display("FAIL exact_idle: got state=%0d credit=%0d required 0/0", state, credit); end
    drain_check("exact_price");
  endtask

  task automatic test_change();
    int t0;
    coin_pulse(4'b0100, t0);
    wait_until(t0 + 3);
    checks++; if (credit !== 10'd200) begin failures++; $display("FAIL credit_200: got %0d required 200", credit); end
    coin_pulse(4'b0100, t0);
    push_exp(0, t0 + 3, 4);
    push_exp(2, t0 + 7, 1);
    push_exp(1, t0 + 10, 1);
    wait_until(t0 + 3);
    checks++; if (credit !== 10'd150) begin failures++; $display("FAIL change_loaded: got %0d required 150", credit); end
    wait_until(t0 + 8);
    checks++; if (state !== 3'd3 || credit !== 10'd50) begin failures++; $display("FAIL change_mid: got state=%0d credit=%0d required 3/50", state, credit); end
    wait_until(t0 + 11);
    checks++; if (state !== 3'd0 || credit !== 10'd0) begin failures++; $display("FAIL change_idle: got state=%0d credit=%0d required 0/0", state, credit); end
    repeat (3) @(negedge clk);
    drain_check("change");
  endtask

  task automatic test_refund();
    int t0;
    coin_pulse(4'b0010, t0);
    coin_pulse(4'b0001, t0);
    wait_until(t0 + 3);
    checks++; if (credit !== 10'd150) begin failures++; $display("FAIL refund_credit: got %0d required 150", credit); end
    coin_pulse(4'b1000, t0);
    push_exp(2, t0 + 3, 1);
    push_exp(1, t0 + 6, 1);
    wait_until(t0 + 3);
    checks++; if (state !== 3'd4 || busy !== 1'b1) begin failures++; $display("FAIL refund_state: got state=%0d busy=%b required 4/1", state, busy); end
    wait_until(t0 + 7);
    checks++; if (state !== 3'd0 || credit !== 10'd0) begin failures++; $display("FAIL refund_idle: got state=%0d credit=%0d required 0/0", state, credit); end
    repeat (3) @(negedge clk);
    drain_check("refund");
  endtask

  task automatic test_reject();
    int t0, t1, t2;
    coin_pulse(4'b0101, t0);           // coin50 and coin200 together
    push_exp(4, t0 + 3, 1);
    wait_until(t0 + 3);
    checks++; if (credit !== 10'd50) begin failures++; $display("FAIL simul_credit: got %0d required 50", credit); end
    coin_pulse(4'b0100, t1);           // 250 -> VEND, no change
    push_exp(0, t1 + 3, 4);
    coin_pulse(4'b0001, t2);           // pushed during VEND
    push_exp(4, t2 + 3, 1);
    wait_until(t1 + 8);
    checks++; if (credit !== 10'd0 || state !== 3'd0) begin failures++; $display("FAIL vend_reject_credit: got credit=%0d state=%0d required 0/0", credit, state); end
    repeat (3) @(negedge clk);
    drain_check("reject");
  endtask

  task automatic test_reset_mid_change();
    int t0;
    coin_pulse(4'b0100, t0);
    coin_pulse(4'b0100, t0);
    push_exp(0, t0 + 3, 4);
    push_exp(2, t0 + 7, 1);
    wait_until(t0 + 8);                // second CHANGE cycle
    reset  = 1'b1;
    coin50 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (state !== 3'd0 || credit !== 10'd0) begin failures++; $display("FAIL midreset: got state=%0d credit=%0d required 0/0", state, credit); end
    checks++; if (busy !== 1'b0 || vend !== 1'b0) begin failures++; $display("FAIL midreset_busy: got busy=%b vend=%b required 0/0", busy, vend); end
    wait_until(t0 + 14);
    coin50 = 1'b0;
    wait_until(t0 + 17);
    checks++; if (credit !== 10'd0 || state !== 3'd0) begin failures++; $display("FAIL midreset_held_coin: got credit=%0d state=%0d required 0/0", credit, state); end
    drain_check("reset_mid_change");
  endtask

  task automatic test_timeout();
    int t0;
    coin_pulse(4'b0010, t0);
`ifdef VEND_TIMEOUT_EN
    push_exp(2, t0 + 13, 1);
    wait_until(t0 + 12);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL timeout_early: got state=%0d required 1", state); end
    wait_until(t0 + 13);
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL timeout_refund: got state=%0d required 4", state); end
    wait_until(t0 + 15);
    checks++; if (state !== 3'd0 || credit !== 10'd0) begin failures++; $display("FAIL timeout_idle: got state=%0d credit=%0d required 0/0", state, credit); end
`else
    wait_until(t0 + 53);
    checks++; if (credit !== 10'd100 || state !== 3'd1) begin failures++; $display("FAIL no_timeout: got credit=%0d state=%0d required 100/1", credit, state); end
    coin_pulse(4'b1000, t0);
    push_exp(2, t0 + 3, 1);
    wait_until(t0 + 5);
    checks++; if (state !== 3'd0 || credit !== 10'd0) begin failures++; $display("FAIL no_timeout_cancel: got state=%0d credit=%0d required 0/0", state, credit); end
`endif
    repeat (3) @(negedge clk);
    drain_check("timeout");
  endtask

  initial begin
    clk     = 1'b0;
    reset   = 1'b1;
    coin50  = 1'b0;
    coin100 = 1'b0;
    coin200 = 1'b0;
    cancel  = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_exact_price();
    test_change();
    test_refund();
    test_reject();
    test_reset_mid_change();
    test_timeout();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
